rotary_filter: RTL

Front-end conditioning stage for the S3E rotary encoder.
- Synchronises and decodes the raw quadrature lines (A, B) and debounces the push contact.
- Produces the packed status byte consumed by the Picoblaze I/O interface on its rotary/LCD input port, address offset 3'b010.
- Provides a sticky rotation-event flag with a software acknowledge, so that no detent is lost between Picoblaze polls.

---
 rtl/rotary_pkg.sv | 20 ++
 rtl/rotary_filter_if.sv | 40 ++++
 rtl/rotary_filter_debounce.sv | 77 +++++++
 rtl/rotary_filter.sv | 102 ++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rotary_pkg: status-bit indices and debounce state encoding shared    |
// | by the rotary encoder front end.                   Revision: 1.0     |
// +--------------------------------------------------------------------+
package rotary_pkg;

    localparam int RS_EVENT = 0;
    localparam int RS_DIR   = 1;
    localparam int RS_PRESS = 2;
    localparam int RS_Q1    = 3;
    localparam int RS_Q2    = 4;

    typedef enum logic [0:0] {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/rotary_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rotary_filter_if: encoder lines, ack and status bus of the rotary    |
// | front end. rot_count exists only with ROTARY_COUNT_EN. Rev: 1.0      |
// +--------------------------------------------------------------------+
interface rotary_filter_if
`ifdef ROTARY_COUNT_EN
#(
    parameter int CNT_W = 16
)
`endif
;
    logic       rotary_a;
    logic       rotary_b;
    logic       rotary_press;
    logic       event_ack;
    logic [7:0] rot_status;
    logic       rot_event_pulse;
`ifdef ROTARY_COUNT_EN
    logic [CNT_W-1:0] rot_count;
`endif

    modport master (
        output rotary_a, rotary_b, rotary_press, event_ack,
        input  rot_status, rot_event_pulse
`ifdef ROTARY_COUNT_EN
        , input rot_count
`endif
    );

    modport slave (
        input  rotary_a, rotary_b, rotary_press, event_ack,
        output rot_status, rot_event_pulse
`ifdef ROTARY_COUNT_EN
        , output rot_count
`endif
    );

endinterface
`default_nettype wire

// File: rtl/rotary_filter_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_sync: 2-flop synchroniser followed by a STABLE/COUNTING     |
// | debounce FSM with a DB_CYCLES stability window.    Revision: 1.0     |
// +--------------------------------------------------------------------+
module debounce_sync
    import rotary_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_din,
    output logic      o_db
);

    // Output flips once the input has differed for DB_CYCLES consecutive samples.
    localparam logic [15:0] c_LAST = 16'(DB_CYCLES - 2);

    logic        r_s1;
    logic        r_s2;
    logic        r_db;
    logic [15:0] r_cnt;
    db_state_t   r_state;
    db_state_t   w_next;
    logic        w_diff;
    logic        w_done;
    logic        w_cnt_inc;
    logic        w_db_load;

    assign w_diff = r_s2 ^ r_db;
    assign w_done = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DB_STABLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DB_STABLE:   if (w_diff) w_next = DB_COUNTING;
            DB_COUNTING: if (!w_diff || w_done) w_next = DB_STABLE;
            default:     w_next = DB_STABLE;
        endcase
    end

    always_comb begin
        w_cnt_inc = 1'b0;
        w_db_load = 1'b0;
        if (r_state == DB_COUNTING && w_diff) begin
            w_cnt_inc = !w_done;
            w_db_load = w_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else begin
            r_s1  <= i_din;
            r_s2  <= r_s1;
            r_cnt <= w_cnt_inc ? r_cnt + 16'd1 : 16'd0;
            if (w_db_load) r_db <= r_s2;
        end
    end

    assign o_db = r_db;

endmodule
`default_nettype wire

// File: rtl/rotary_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rotary_filter: quadrature decode, press debounce and sticky event    |
// | status byte. Option macro: ROTARY_COUNT_EN (detent counter). Rev 1.0 |
// +--------------------------------------------------------------------+
module rotary_filter
    import rotary_pkg::*;
#(
    parameter int DB_CYCLES = 50000
`ifdef ROTARY_COUNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  wire logic       clk,
    input  wire logic       reset,
    rotary_filter_if.slave  bus
);

    logic       r_a_s1;
    logic       r_a_s2;
    logic       r_b_s1;
    logic       r_b_s2;
    logic       r_q1;
    logic       r_q2;
    logic       r_q1_d;
    logic       r_q2_d;
    logic       r_pulse;
    logic       r_dir;
    logic       r_event;
    logic       w_detent;
    logic       w_press_db;
    logic [7:0] w_status;

    debounce_sync #(
        .DB_CYCLES (DB_CYCLES)
    ) u_press_db (
        .clk   (clk),
        .reset (reset),
        .i_din (bus.rotary_press),
        .o_db  (w_press_db)
    );

    assign w_detent = r_q1 & ~r_q1_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_s1  <= 1'b0;
            r_a_s2  <= 1'b0;
            r_b_s1  <= 1'b0;
            r_b_s2  <= 1'b0;
            r_q1    <= 1'b0;
            r_q2    <= 1'b0;
            r_q1_d  <= 1'b0;
            r_q2_d  <= 1'b0;
            r_pulse <= 1'b0;
            r_dir   <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_a_s1  <= bus.rotary_a;
            r_a_s2  <= r_a_s1;
            r_b_s1  <= bus.rotary_b;
            r_b_s2  <= r_b_s1;
            // q1 follows A when A==B, q2 follows B when A!=B
            if (r_a_s2 == r_b_s2) r_q1 <= r_a_s2;
            else                  r_q2 <= r_b_s2;
            r_q1_d  <= r_q1;
            r_q2_d  <= r_q2;
            r_pulse <= w_detent;
            if (w_detent) r_dir <= ~r_q2_d;
            // A pulse coinciding with an ack must not be lost
            r_event <= r_pulse | (r_event & ~bus.event_ack);
        end
    end

`ifdef ROTARY_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_detent) begin
            r_count <= r_q2_d ? r_count - CNT_W'(1) : r_count + CNT_W'(1);
        end
    end

    assign bus.rot_count = r_count;
`endif

    always_comb begin
        w_status           = 8'h00;
        w_status[RS_EVENT] = r_event;
        w_status[RS_DIR]   = r_dir;
        w_status[RS_PRESS] = w_press_db;
        w_status[RS_Q1]    = r_q1;
        w_status[RS_Q2]    = r_q2;
    end

    assign bus.rot_status      = w_status;
    assign bus.rot_event_pulse = r_pulse;

endmodule
`default_nettype wire
